// File: rtl/med9_pkg.sv
// med9_pkg: shared types and sizes for the 3x3 median-of-medians scheduler
package med9_pkg;
    localparam int NUM_TAPS = 9;
    localparam int ROW      = 3;
    localparam int DEF_W    = 8;

    typedef enum logic [2:0] {
        LOAD,
        M0,
        M1,
        M2,
        MF,
        OUT
    } state_t;
endpackage

// File: rtl/med9_scheduler_if.sv
// med9_scheduler_if: sample-in / result-out handshake bundle with flush and busy
interface med9_scheduler_if #(parameter int W = 8) ();
    logic         flush;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_data;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_data;
    logic         busy;

    modport master (
        output flush, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, busy
    );

    modport slave (
        input  flush, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, busy
    );
endinterface

// File: rtl/med9_scheduler_median.sv
// median: combinational unsigned median of three W-bit values
module median #(parameter int W = 8) (
    input  logic [W-1:0] a0,
    input  logic [W-1:0] a1,
    input  logic [W-1:0] a2,
    output logic [W-1:0] out
);
    logic [W-1:0] lo, hi, hi_c;

    // median = max(min(a0,a1), min(max(a0,a1),a2)); ties fall out naturally
    always_comb begin
        lo   = (a0 < a1) ? a0 : a1;
        hi   = (a0 < a1) ? a1 : a0;
        hi_c = (hi < a2) ? hi : a2;
        out  = (lo < hi_c) ? hi_c : lo;
    end
endmodule

// File: rtl/med9_scheduler.sv
// med9_scheduler: serial 9-sample window into one shared median unit over four compute cycles
module med9_scheduler
    import med9_pkg::*;
#(
    parameter int W = DEF_W
) (
    input logic              clk,
    input logic              rst,
    med9_scheduler_if.slave  bus
);
    state_t       state, state_nx;
    logic [3:0]   cnt;
    logic [W-1:0] p [NUM_TAPS];
    logic [W-1:0] r [ROW];
    logic [W-1:0] res;
    logic [W-1:0] a0, a1, a2, med;
    logic         accept;

    assign accept        = bus.in_valid && bus.in_ready;
    assign bus.in_ready  = state == LOAD;
    assign bus.out_valid = state == OUT;
    assign bus.out_data  = res;
    assign bus.busy      = !(state == LOAD && cnt == 4'd0);

    median #(.W(W)) u_median (
        .a0  (a0),
        .a1  (a1),
        .a2  (a2),
        .out (med)
    );

    // Steer one row (or the row medians) into the shared median unit; p0..p2 when idle
    always_comb begin
        a0 = p[0];
        a1 = p[1];
        a2 = p[2];
        case (state)
            M1: begin
                a0 = p[3];
                a1 = p[4];
                a2 = p[5];
            end
            M2: begin
                a0 = p[6];
                a1 = p[7];
                a2 = p[8];
            end
            MF: begin
                a0 = r[0];
                a1 = r[1];
                a2 = r[2];
            end
            default: ;
        endcase
    end

    // Next-state: load until the 9th accept, four fixed compute steps, hold until taken; flush wins
    always_comb begin
        state_nx = state;
        case (state)
            LOAD:    if (accept && cnt == 4'(NUM_TAPS - 1)) state_nx = M0;
            M0:      state_nx = M1;
            M1:      state_nx = M2;
            M2:      state_nx = MF;
            MF:      state_nx = OUT;
            OUT:     if (bus.out_ready) state_nx = LOAD;
            default: state_nx = LOAD;
        endcase
        if (bus.flush) state_nx = LOAD;
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= LOAD;
        else     state <= state_nx;
    end

    // Sample capture, row-median and result registers; flush drops any coincident sample
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            res <= '0;
            for (int i = 0; i < NUM_TAPS; i++) p[i] <= '0;
            for (int i = 0; i < ROW; i++) r[i] <= '0;
        end else if (bus.flush) begin
            cnt <= '0;
        end else begin
            case (state)
                LOAD: if (accept) begin
                    p[cnt] <= bus.in_data;
                    cnt    <= (cnt == 4'(NUM_TAPS - 1)) ? 4'd0 : cnt + 4'd1;
                end
                M0:      r[0] <= med;
                M1:      r[1] <= med;
                M2:      r[2] <= med;
                MF:      res  <= med;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_med9_scheduler.sv
// tb_med9_scheduler: table-driven windows plus directed hold, flush and reset sequences
module tb_med9_scheduler;
    logic clk = 0;
    logic rst = 1;
    int   n_pass = 0;
    int   n_total = 0;
    int   n_deliv = 0;
    logic [7:0] last_deliv = '0;

    typedef struct {
        logic [7:0] s [9];
        logic [7:0] exp;
        bit         bub;
    } vec_t;

    vec_t tbl [7];

    med9_scheduler_if #(.W(8)) bus ();

    med9_scheduler #(.W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Count results actually delivered by handshake
    always @(posedge clk) begin
        if (!rst && bus.out_valid && bus.out_ready && !bus.flush) begin
            n_deliv    <= n_deliv + 1;
            last_deliv <= bus.out_data;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_window(input logic [7:0] s [9], input bit bub);
        for (int i = 0; i < 9; i++) begin
            if (bub) begin
                bus.in_valid = 0;
                repeat ($urandom_range(0, 2)) tick();
            end
            chk("in_ready_load", {31'd0, bus.in_ready}, 1);
            bus.in_valid = 1;
            bus.in_data  = s[i];
            tick();
        end
        bus.in_valid = 0;
    endtask

    task automatic wait_out(input logic [7:0] exp);
        int lat = 0;
        while (!bus.out_valid && lat < 10) begin
            chk("in_ready_compute", {31'd0, bus.in_ready}, 0);
            tick();
            lat++;
        end
        chk("latency", lat, 4);
        chk("out_data", {24'd0, bus.out_data}, {24'd0, exp});
    endtask

    task automatic deliver(input logic [7:0] exp);
        int d0 = n_deliv;
        bus.out_ready = 1;
        tick();
        bus.out_ready = 0;
        chk("deliv_count", n_deliv, d0 + 1);
        chk("deliv_data", {24'd0, last_deliv}, {24'd0, exp});
        chk("in_ready_after", {31'd0, bus.in_ready}, 1);
        chk("out_valid_after", {31'd0, bus.out_valid}, 0);
    endtask

    initial begin
        int d0;
        tbl[0] = '{'{8'd4, 8'd64, 8'd8, 8'd128, 8'd32, 8'd16, 8'd2, 8'd16, 8'd4}, 8'd8, 1'b0};
        tbl[1] = '{'{8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA, 8'hAA}, 8'hAA, 1'b0};
        tbl[2] = '{'{8'd9, 8'd9, 8'd1, 8'd0, 8'd255, 8'd255, 8'd7, 8'd3, 8'd5}, 8'd9, 1'b0};
        tbl[3] = '{'{8'd4, 8'd64, 8'd8, 8'd128, 8'd32, 8'd16, 8'd2, 8'd16, 8'd4}, 8'd8, 1'b1};
        tbl[4] = '{'{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9}, 8'd5, 1'b1};
        tbl[5] = '{'{8'd255, 8'd0, 8'd128, 8'd10, 8'd20, 8'd30, 8'd200, 8'd100, 8'd150}, 8'd128, 1'b0};
        tbl[6] = '{'{8'd5, 8'd5, 8'd9, 8'd3, 8'd3, 8'd3, 8'd0, 8'd0, 8'd1}, 8'd3, 1'b1};

        bus.flush     = 0;
        bus.in_valid  = 0;
        bus.in_data   = '0;
        bus.out_ready = 0;

        #12;
        chk("rst_in_ready", {31'd0, bus.in_ready}, 1);
        chk("rst_out_valid", {31'd0, bus.out_valid}, 0);
        chk("rst_out_data", {24'd0, bus.out_data}, 0);
        chk("rst_busy", {31'd0, bus.busy}, 0);
        rst = 0;
        tick();

        for (int v = 0; v < 7; v++) begin
            load_window(tbl[v].s, tbl[v].bub);
            wait_out(tbl[v].exp);
            deliver(tbl[v].exp);
        end

        // out_ready held low for 6 cycles in OUT; inputs must be ignored
        load_window(tbl[5].s, 0);
        wait_out(8'd128);
        bus.in_valid = 1;
        bus.in_data  = 8'd77;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("hold_out_valid", {31'd0, bus.out_valid}, 1);
            chk("hold_out_data", {24'd0, bus.out_data}, 128);
            chk("hold_in_ready", {31'd0, bus.in_ready}, 0);
        end
        bus.in_valid = 0;
        deliver(8'd128);
        chk("hold_busy_idle", {31'd0, bus.busy}, 0);

        // flush after 5 samples, then a fresh window
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1;
            bus.in_data  = 8'd250;
            tick();
        end
        bus.in_valid = 0;
        chk("partial_busy", {31'd0, bus.busy}, 1);
        bus.flush = 1;
        tick();
        bus.flush = 0;
        chk("flush_busy", {31'd0, bus.busy}, 0);
        load_window(tbl[4].s, 0);
        wait_out(8'd5);
        deliver(8'd5);

        // flush coinciding with a sample handshake drops that sample
        for (int i = 0; i < 3; i++) begin
            bus.in_valid = 1;
            bus.in_data  = 8'd200;
            tick();
        end
        bus.flush = 1;
        tick();
        bus.flush    = 0;
        bus.in_valid = 0;
        chk("flush_hs_busy", {31'd0, bus.busy}, 0);

        // flush in OUT with out_ready=1: result is not delivered
        load_window(tbl[2].s, 0);
        wait_out(8'd9);
        d0 = n_deliv;
        bus.flush     = 1;
        bus.out_ready = 1;
        tick();
        bus.flush     = 0;
        bus.out_ready = 0;
        chk("flush_out_deliv", n_deliv, d0);
        chk("flush_out_valid", {31'd0, bus.out_valid}, 0);
        chk("flush_out_in_ready", {31'd0, bus.in_ready}, 1);

        // asynchronous reset while in M1
        load_window(tbl[0].s, 0);
        tick();
        chk("pre_rst_busy", {31'd0, bus.busy}, 1);
        #2 rst = 1;
        #1;
        chk("arst_in_ready", {31'd0, bus.in_ready}, 1);
        chk("arst_out_valid", {31'd0, bus.out_valid}, 0);
        chk("arst_out_data", {24'd0, bus.out_data}, 0);
        chk("arst_busy", {31'd0, bus.busy}, 0);
        #2 rst = 0;
        tick();
        chk("post_rst_in_ready", {31'd0, bus.in_ready}, 1);
        chk("post_rst_busy", {31'd0, bus.busy}, 0);
        chk("post_rst_out_valid", {31'd0, bus.out_valid}, 0);
        load_window(tbl[6].s, 0);
        wait_out(8'd3);
        deliver(8'd3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/med9_scheduler.md
# med9_scheduler

Time-multiplexed 3×3 median-of-medians controller. It accepts a 9-sample window serially and sequences one shared combinational `median` instance (3 × W-bit in, 1 out) over four compute cycles: three row medians, then the median of those. It returns the result on a valid/ready output port. It sits between a pixel/sample streamer and downstream filtering logic, replacing three parallel median units with one.

## Interface
- `W`, default 8: sample width in bits.
- `clk` input, 1 bit: single clock, rising edge.
- `rst` input, 1 bit: asynchronous reset, active-high.
- `flush` input, 1 bit: synchronous abort; discards the partial or complete window.
- `in_valid` input, 1 bit: sample present on `in_data`.
- `in_ready` output, 1 bit: block can accept a sample.
- `in_data` input, W bits: sample. Row-major order p0..p8.
- `out_valid` output, 1 bit: result present.
- `out_ready` input, 1 bit: downstream accepts the result.
- `out_data` output, W bits: median-of-row-medians.
- `busy` output, 1 bit: high in any state except LOAD with cnt==0.

## Operation
- States:
  - LOAD: collect 9 samples.
  - M0, M1, M2: row medians.
  - MF: final median.
  - OUT: hold result.
- LOAD:
  - `in_ready`=1.
  - Accept on `in_valid & in_ready`: p[cnt] <= in_data, cnt++.
  - Accepting with cnt==8: go to M0, cnt <= 0.
  - Bubbles (in_valid=0) are allowed at any point and do not advance cnt.
- M0: mux p0,p1,p2 into the median unit; r0 <= med. Go to M1.
- M1: mux p3,p4,p5; r1 <= med. Go to M2.
- M2: mux p6,p7,p8; r2 <= med. Go to MF.
- MF: mux r0,r1,r2; res <= med. Go to OUT.
- OUT:
  - `out_valid`=1; `out_data`=res, stable until the handshake completes.
  - On `out_ready`, go to LOAD.
- `in_ready`=0 in M0..OUT. Input is not accepted while a window is in flight.
- Median unit inputs are don't-care in LOAD/OUT. Drive them with p0..p2 to avoid extra mux legs.
- Arithmetic: comparisons are unsigned, W-bit. No widening. Ties resolve naturally, e.g. median(5,5,9)=5.
- `flush`:
  - From any state, go to LOAD with cnt <= 0 next edge.
  - A flush with a simultaneous input handshake drops that sample.
  - A flush in OUT drops the result even if `out_ready`=1 that cycle. The result is not counted as delivered.
- Reset:
  - State=LOAD, cnt=0, p/r/res=0.
  - Outputs: `in_ready`=1 after reset release, `out_valid`=0, `out_data`=0, `busy`=0.
  - Reset mid-compute aborts the window; no output is produced.

## Timing
- Edge E accepts the 9th sample.
- M0 occupies E..E+1, M1 E+1..E+2, M2 E+2..E+3, MF E+3..E+4.
- `out_valid` rises at edge E+4: latency of 4 cycles from the last accept.
- Result leaves at the first edge with `out_ready`=1 while in OUT. `in_ready` rises on that same edge.
- Minimum period per window: 9 load + 4 compute + 1 output = 14 cycles.
- `out_valid`/`out_data` are registered (state decode plus res register). There is no combinational path from `out_ready` to `in_ready`.

## Structure
- Shared package `med9_pkg`:
  - State enum: LOAD, M0, M1, M2, MF, OUT.
  - `NUM_TAPS`=9, `ROW`=3.
  - Default `W`.
- One sub-module: existing combinational `median` (ports a0, a1, a2, out), instantiated once.
- Input mux selected by state.
- Sample storage: 9×W register array. 4-bit cnt.

## Test plan
- Window 4,64,8, 128,32,16, 2,16,4, streamed back-to-back with `out_ready`=1:
  - Row medians 8, 32, 4; `out_data`=8.
  - `out_valid` exactly 4 cycles after the 9th accept.
  - `in_ready` low throughout compute.
- Window all 0xAA, then 9,9,1, 0,255,255, 7,3,5: two results, 0xAA then 9 (row medians 9, 255, 5; median = 9). No overlap between windows.
- Random `in_valid` bubbles (~50% duty): same result as the back-to-back run; cnt advances only on handshakes.
- `out_ready` held low 6 cycles in OUT:
  - `out_valid`=1 and `out_data` stable throughout.
  - `in_ready`=0 and inputs ignored.
  - Release → one handshake, then LOAD.
- `flush` after 5 samples, then 9 fresh samples: the result reflects only the fresh window. `flush` in OUT with `out_ready`=1: no output is counted.
- Assert `rst` in M1: all outputs return to reset values immediately (async). After release, `in_ready`=1 with `busy`=0, and the next full window yields the correct median.
